// File: rtl/jpeg_idct_out_buffer.sv
// jpeg_idct_out_buffer
// Level-shifts and saturates column IDCT results, collects them into two
// ping-pong 64-entry block banks, and streams completed blocks out in raster
// order.
//
// Output handshake: a pixel moves downstream on any rising edge where
// outport_valid_o && outport_accept_i. While valid is high and accept is low,
// data/idx/last stay frozen. The input side has no backpressure. Upstream must
// only begin a new block while inport_ready_o is high. Samples that arrive
// while the target bank is still full are dropped and raise overflow_o.
module jpeg_idct_out_buffer #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 img_start_i,
  input  logic                 inport_valid_i,
  input  logic [31:0]          inport_data_i,
  input  logic [5:0]           inport_idx_i,
  output logic                 inport_ready_o,
  output logic                 outport_valid_o,
  output logic [OUT_WIDTH-1:0] outport_data_o,
  output logic [5:0]           outport_idx_o,
  output logic                 outport_last_o,
  input  logic                 outport_accept_i,
  output logic                 overflow_o
);

  localparam int MAX_VAL = (1 << OUT_WIDTH) - 1;

  // Read-side FSM state. Kept as a named enum so checkers can probe r_state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  // Bank storage: address is {bank, raster idx}.
  logic [OUT_WIDTH-1:0]   r_mem [0:127];

  logic [1:0]             r_full;
  logic                   r_wr_bank;
  logic [6:0]             r_wr_count;
  logic                   r_rd_bank;
  logic [5:0]             r_rd_idx;
  logic                   r_overflow;

  logic                   r_out_valid;
  logic [OUT_WIDTH-1:0]   r_out_data;
  logic [5:0]             r_out_idx;
  logic                   r_out_last;

  logic signed [31:0]     w_shifted;
  logic [OUT_WIDTH-1:0]   w_pixel;
  logic                   w_wr_en;
  logic                   w_wr_done;
  logic                   w_rd_en;
  logic [5:0]             w_rd_addr;
  logic                   w_rd_done;

  assign w_shifted = $signed(inport_data_i) + 32'sd128;

  // Saturate the level-shifted sample into the pixel range.
  always_comb begin
    w_pixel = '0;
    if (w_shifted < 0)
      w_pixel = '0;
    else if (w_shifted > MAX_VAL)
      w_pixel = '1;
    else
      w_pixel = w_shifted[OUT_WIDTH-1:0];
  end

  // A sample is stored only when its bank has room; a flush drops it outright.
  assign w_wr_en   = inport_valid_i && !img_start_i && !r_full[r_wr_bank];
  assign w_wr_done = w_wr_en && (r_wr_count == 7'd63);

  // Next-state and read-port control for the streaming side.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_rd_idx;
    w_rd_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank])
          w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_rd_en      = 1'b1;
        w_rd_addr    = 6'd0;
        w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (outport_accept_i) begin
          if (r_rd_idx == 6'd63) begin
            w_rd_done    = 1'b1;
            w_state_next = r_full[~r_rd_bank] ? ST_LOAD : ST_IDLE;
          end else begin
            // Prefetch the next pixel so continuous accept has no bubbles.
            w_rd_en   = 1'b1;
            w_rd_addr = r_rd_idx + 6'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (img_start_i) begin
      w_state_next = ST_IDLE;
      w_rd_en      = 1'b0;
      w_rd_done    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Bank RAM write port (no reset: contents are only read once a bank is full).
  always_ff @(posedge clk_i) begin
    if (w_wr_en)
      r_mem[{r_wr_bank, inport_idx_i}] <= w_pixel;
  end

  // Write pointer, sample count and sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_bank  <= 1'b0;
      r_wr_count <= 7'd0;
      r_overflow <= 1'b0;
    end else if (img_start_i) begin
      r_wr_bank  <= 1'b0;
      r_wr_count <= 7'd0;
      r_overflow <= 1'b0;
    end else begin
      if (inport_valid_i && r_full[r_wr_bank])
        r_overflow <= 1'b1;
      if (w_wr_en) begin
        if (w_wr_done) begin
          r_wr_count <= 7'd0;
          r_wr_bank  <= ~r_wr_bank;
        end else begin
          r_wr_count <= r_wr_count + 7'd1;
        end
      end
    end
  end

  // Bank-full flags: writer sets, reader clears (always different banks).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full <= 2'b00;
    end else if (img_start_i) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_done)
        r_full[r_wr_bank] <= 1'b1;
      if (w_rd_done)
        r_full[r_rd_bank] <= 1'b0;
    end
  end

  // Read bank and raster pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_bank <= 1'b0;
      r_rd_idx  <= 6'd0;
    end else if (img_start_i) begin
      r_rd_bank <= 1'b0;
      r_rd_idx  <= 6'd0;
    end else if (w_rd_done) begin
      r_rd_bank <= ~r_rd_bank;
      r_rd_idx  <= 6'd0;
    end else if (w_rd_en) begin
      r_rd_idx  <= w_rd_addr;
    end
  end

  // Output register doubles as the synchronous RAM read register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= 6'd0;
      r_out_last  <= 1'b0;
    end else if (img_start_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= 6'd0;
      r_out_last  <= 1'b0;
    end else if (w_rd_en) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mem[{r_rd_bank, w_rd_addr}];
      r_out_idx   <= w_rd_addr;
      r_out_last  <= (w_rd_addr == 6'd63);
    end else if (w_rd_done) begin
      r_out_valid <= 1'b0;
    end
  end

  assign inport_ready_o  = !(r_full[0] && r_full[1]);
  assign outport_valid_o = r_out_valid;
  assign outport_data_o  = r_out_data;
  assign outport_idx_o   = r_out_idx;
  assign outport_last_o  = r_out_last;
  assign overflow_o      = r_overflow;

endmodule

// File: doc/jpeg_idct_out_buffer.md
# jpeg_idct_out_buffer

Pixel reassembly and output buffer sitting directly downstream of the column IDCT stage (`jpeg_idct_y`). It receives 32-bit signed IDCT results one per cycle with a transposed block index. It level-shifts (+128) and saturates each result to 8 bits, and writes it into one of two 64-entry block banks (ping-pong). Completed blocks are streamed out in raster order (idx 0..63) under a valid/accept handshake to the colour-conversion/output stage.

## Interface
- `OUT_WIDTH`, default 8: output pixel width; saturation range is 0..2^OUT_WIDTH-1.
- `clk_i`  input  1  clock; all state changes on the rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `img_start_i`  input  1  synchronous flush: both banks empty, pointers zeroed, `overflow_o` cleared.
- `inport_valid_i`  input  1  one IDCT sample present this cycle; no backpressure possible.
- `inport_data_i`  input  32  signed IDCT result (pre level-shift).
- `inport_idx_i`  input  6  raster position 0..63 of the sample within its block; arrival order arbitrary.
- `inport_ready_o`  output  1  at least one bank not full; upstream starts a new block only when high.
- `outport_valid_o`  output  1  pixel present.
- `outport_data_o`  output  OUT_WIDTH  saturated pixel.
- `outport_idx_o`  output  6  raster index of pixel, 0..63 in order.
- `outport_last_o`  output  1  high with idx 63.
- `outport_accept_i`  input  1  downstream takes pixel when valid && accept.
- `overflow_o`  output  1  sticky: sample arrived while both banks full.

## Operation
- Arithmetic: `v = inport_data_i + 128` (32-bit signed); v < 0 -> 0; v > 255 -> 255; else v[7:0].
- Write side: `wr_bank` (1 bit), `wr_count` (7 bits). Each accepted sample writes bank[wr_bank][inport_idx_i] and increments `wr_count`. Write at count 63 sets `full[wr_bank]`, zeroes `wr_count`, toggles `wr_bank`.
- Duplicate idx within a block overwrites. Counting is by sample, not by idx coverage.
- Write while `full[wr_bank]` set: sample dropped, counters unchanged, `overflow_o` set until `img_start_i` or reset.
- Read FSM states: IDLE, LOAD, STREAM.
  - IDLE -> LOAD when `full[rd_bank]`.
  - LOAD: registered RAM read of idx 0 -> STREAM.
  - STREAM: output register holds pixel; on accept, advance `rd_idx` and present next pixel the following cycle (prefetch, so no bubbles under continuous accept).
  - Accept of idx 63: clear `full[rd_bank]`, toggle `rd_bank`, `rd_idx`=0. Go to LOAD if other bank full, else IDLE.
- Output data/idx/last held stable while valid && !accept.
- `inport_ready_o = !(full[0] && full[1])`, combinational from registered flags.
- Same-cycle write completing bank A and read freeing bank B: both take effect; ready stays high.
- `img_start_i` has priority over all other events: FSM to IDLE, `outport_valid_o` low next cycle, in-flight pixel discarded, same-cycle input sample discarded.

## Timing
- Reset values: `outport_valid_o`=0, `outport_data_o`=0, `outport_idx_o`=0, `outport_last_o`=0, `overflow_o`=0, `inport_ready_o`=1; banks empty, `wr_bank`=`rd_bank`=0.
- Latency: the 64th write is captured at edge N, with `full` set at N. LOAD occupies edge N+1. `outport_valid_o` rises after edge N+2.
- Throughput: 1 pixel/cycle with continuous accept.
- Back-to-back full blocks: one LOAD bubble cycle between idx 63 of block k and idx 0 of block k+1.
- `inport_ready_o` falls in the cycle after the edge that fills the second bank. It rises in the cycle after the edge accepting idx 63.
- Bank memory: 2x64xOUT_WIDTH, one write port, one synchronous read port. Concurrent write and read always target different banks.

## Test plan
- Single block, inputs -128..-65 at transposed idx order, accept tied high -> 64 pixels, idx 0..63 in order, data 0..63, last only on idx 63, valid first high 2 cycles after 64th write.
- Saturation: inputs -1000, -129, -128, 127, 128, 5000 -> 0, 0, 0, 255, 255, 255.
- Backpressure: accept toggles 1010… while streaming -> every pixel delivered exactly once; data held stable across non-accept cycles.
- Ping-pong full: 3 blocks pushed with accept low -> ready low after 128th sample; 129th..192nd dropped; overflow_o=1. Then accept high -> exactly blocks 1 and 2 output.
- img_start_i mid-stream at pixel 20 of block 1, with bank 1 half written -> valid low next cycle, ready=1, overflow cleared; a fresh block then outputs from idx 0 correctly.
- Async reset asserted mid-stream, between clock edges -> all outputs at reset values immediately, without waiting for a clock edge.
